arbiter_router_rr_scheduler: RTL and testbench
==============================================

ARBITER_ROUTER_RR_SCHEDULER -- requirements
Module: arbiter_router_rr_scheduler

Interface
REQ-001 Parameter nbits, default 32, payload width per input.
REQ-002 Parameter ninputs, default 3, number of requesters (>=2).
REQ-003 Parameter max_burst, default 4, max messages accepted per grant before forced rotation (>=1).
REQ-004 Derived addr_nbits = $clog2(ninputs); cnt width = $clog2(max_burst)+1.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-007 istream_val  in  1 x ninputs  requester i has a valid message.
REQ-008 istream_rdy  out  1 x ninputs  requester i's message is accepted this cycle if val also high.
REQ-009 istream_msg  in  nbits x ninputs  requester payloads.
REQ-010 ostream_val  out  1  output buffer holds a message.
REQ-011 ostream_rdy  in  1  downstream accepts output this cycle.
REQ-012 ostream_msg  out  addr_nbits+nbits  {source index, payload}, index in MSBs.
REQ-013 grant_val  out  1  a requester currently holds the grant (state GRANT).
REQ-014 grant_idx  out  addr_nbits  index of current/last granted requester.

Function
REQ-015 FSM states IDLE and GRANT; registers: state, grant_idx, ptr (round-robin start), cnt, output buffer (val, msg).
REQ-016 IDLE: if any istream_val, grant_idx <= first i with val high searching ptr, ptr+1, ... mod ninputs; cnt <= 0; state <= GRANT; else stay IDLE.
REQ-017 Grant decision is registered: first accept from a new grantee occurs no earlier than the cycle after leaving IDLE.
REQ-018 istream_rdy[i] = (state==GRANT) && (i==grant_idx) && (!ostream_val || ostream_rdy); all other rdy bits 0.
REQ-019 Accept = istream_val[grant_idx] && istream_rdy[grant_idx]; on accept buffer loads {grant_idx, istream_msg[grant_idx]}, ostream_val <= 1, cnt <= cnt+1.
REQ-020 Buffer drain with no accept (ostream_val && ostream_rdy) sets ostream_val <= 0; simultaneous drain+accept keeps ostream_val 1 with new message (full throughput, 1-cycle accept-to-output latency).
REQ-021 ostream_msg and ostream_val stable while ostream_val && !ostream_rdy.
REQ-022 GRANT release on accept with cnt==max_burst-1 (quota reached), or on any GRANT cycle with istream_val[grant_idx]==0; release: state <= IDLE, ptr <= (grant_idx+1) mod ninputs, cnt <= 0.
REQ-023 ptr wrap: grant_idx==ninputs-1 yields ptr 0; never produces an out-of-range index for non-power-of-2 ninputs.
REQ-024 Buffer continues draining independently of FSM state; a release never discards a buffered message.
REQ-025 max_burst==1: every accept releases; strict one-message round-robin.
REQ-026 grant_val = (state==GRANT); grant_idx holds last value in IDLE.
REQ-027 No starvation: a continuously valid requester is granted within ninputs-1 other grants.

Reset
REQ-028 While reset==0, immediately: state IDLE, grant_idx 0, ptr 0, cnt 0, ostream_val 0, ostream_msg 0, grant_val 0, all istream_rdy 0.
REQ-029 Reset mid-burst discards buffered message; first grant after release searches from index 0.

Verification
REQ-030 All 3 val high, ostream_rdy=1, max_burst=4 -> ostream_msg index field 0,0,0,0,1,1,1,1,2,2,2,2,0 with one idle cycle per grant change.
REQ-031 Only input 2 valid, msg 0xA5 -> grant_val at cycle+1, accept cycle+1, ostream_val cycle+2 with ostream_msg {2,0x000000A5}.
REQ-032 Buffer full, ostream_rdy=0 for 5 cycles -> all istream_rdy 0, ostream_msg unchanged; ostream_rdy=1 -> drain and accept same cycle.
REQ-033 Input 0 drops val after 2 accepts, input 1 valid -> release, ptr=1, next grant_idx 1, cnt restarts at 0.
REQ-034 Last grant 2, inputs 0 and 2 valid -> next grant_idx 0 (wrap).
REQ-035 reset=0 asserted mid-burst with ostream_val=1 -> all outputs 0 same cycle without clock; after release inputs 1,2 valid -> grant_idx 1.

Source files
------------

// File: rtl/arbiter_router_rr_scheduler.sv
// Round-robin arbiter/router: grants one requester at a time for up to max_burst
// messages and forwards each accepted payload, tagged with its source index, through a one-entry buffer.
module arbiter_router_rr_scheduler #(
  parameter int nbits     = 32,
  parameter int ninputs   = 3,
  parameter int max_burst = 4,
  localparam int addr_nbits = $clog2(ninputs)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ninputs-1:0]            istream_val,
  output logic [ninputs-1:0]            istream_rdy,
  input  logic [ninputs*nbits-1:0]      istream_msg,
  output logic                          ostream_val,
  input  logic                          ostream_rdy,
  output logic [addr_nbits+nbits-1:0]   ostream_msg,
  output logic                          grant_val,
  output logic [addr_nbits-1:0]         grant_idx
);

  localparam int CNT_W = $clog2(max_burst) + 1;
  localparam int OUT_W = addr_nbits + nbits;
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(max_burst - 1);
  localparam logic [addr_nbits-1:0] LAST_IDX = addr_nbits'(ninputs - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                r_state, w_state_nxt;
  logic [addr_nbits-1:0] r_grant_idx, w_grant_idx_nxt;
  logic [addr_nbits-1:0] r_ptr, w_ptr_nxt;
  logic [addr_nbits-1:0] w_sel, w_next_ptr;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_oval;
  logic [OUT_W-1:0]      r_omsg;
  logic                  w_found, w_gval, w_free, w_accept;
  logic [nbits-1:0]      w_gmsg;

  // Rotating priority: first pass covers ptr..ninputs-1, second pass wraps to 0..ptr-1.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < ninputs; i++) begin
      if (!w_found && istream_val[i] && (addr_nbits'(i) >= r_ptr)) begin
        w_found = 1'b1;
        w_sel   = addr_nbits'(i);
      end
    end
    for (int i = 0; i < ninputs; i++) begin
      if (!w_found && istream_val[i]) begin
        w_found = 1'b1;
        w_sel   = addr_nbits'(i);
      end
    end
  end

  always_comb begin
    w_gval = 1'b0;
    w_gmsg = '0;
    for (int i = 0; i < ninputs; i++) begin
      if (r_grant_idx == addr_nbits'(i)) begin
        w_gval = istream_val[i];
        w_gmsg = istream_msg[i*nbits +: nbits];
      end
    end
  end

  assign w_free     = !r_oval || ostream_rdy;
  assign w_accept   = (r_state == S_GRANT) && w_gval && w_free;
  assign w_next_ptr = (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + 1'b1;

  always_comb begin
    istream_rdy = '0;
    for (int i = 0; i < ninputs; i++) begin
      istream_rdy[i] = (r_state == S_GRANT) && w_free && (r_grant_idx == addr_nbits'(i));
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_idx_nxt = r_grant_idx;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt     = S_GRANT;
          w_grant_idx_nxt = w_sel;
          w_cnt_nxt       = '0;
        end
      end
      S_GRANT: begin
        // Release when the grantee goes quiet or its burst quota is used up.
        if (!w_gval || (w_accept && (r_cnt == LAST_CNT))) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_next_ptr;
          w_cnt_nxt   = '0;
        end else if (w_accept) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_grant_idx <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Output buffer drains independently of the FSM; a new accept overwrites a draining entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_oval <= 1'b0;
      r_omsg <= '0;
    end else if (w_accept) begin
      r_oval <= 1'b1;
      r_omsg <= {r_grant_idx, w_gmsg};
    end else if (r_oval && ostream_rdy) begin
      r_oval <= 1'b0;
    end
  end

  assign ostream_val = r_oval;
  assign ostream_msg = r_omsg;
  assign grant_val   = (r_state == S_GRANT);
  assign grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_arbiter_router_rr_scheduler.sv
// Bench for arbiter_router_rr_scheduler: cycle vector table plus scoreboarded
// burst/backpressure/reset sequences with the default 3-input, 32-bit, burst-4 configuration.
module tb_arbiter_router_rr_scheduler;

  logic        clk;
  logic        reset;
  logic [2:0]  istream_val;
  logic [2:0]  istream_rdy;
  logic [95:0] istream_msg;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [33:0] ostream_msg;
  logic        grant_val;
  logic [1:0]  grant_idx;

  logic [31:0] lanes [3];
  assign istream_msg = {lanes[2], lanes[1], lanes[0]};

  arbiter_router_rr_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg),
    .grant_val   (grant_val),
    .grant_idx   (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [2:0] val;
    logic       ordy;
    logic       gval;
    logic [1:0] gidx;
    logic [2:0] rdy;
    logic       oval;
    logic [1:0] oidx;
  } vec_t;

  vec_t        vec [$];
  logic [33:0] sb_q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic sb_sample();
    logic [33:0] e;
    if (ostream_val && ostream_rdy) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got %0h expected no output", ostream_msg);
      end else begin
        e = sb_q.pop_front();
        check("sb_msg", 64'(ostream_msg), 64'(e));
      end
    end
  endtask

  function automatic vec_t mk(input logic [2:0] val, input logic ordy, input logic gval,
                              input logic [1:0] gidx, input logic [2:0] rdy,
                              input logic oval, input logic [1:0] oidx);
    vec_t v;
    v.val = val; v.ordy = ordy; v.gval = gval; v.gidx = gidx;
    v.rdy = rdy; v.oval = oval; v.oidx = oidx;
    return v;
  endfunction

  task automatic reset_pulse();
    istream_val = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int nout;
    int last;
    logic [1:0] ei;

    // Only input 2 valid, then drop.
    vec.push_back(mk(3'b100, 1, 0, 2'd0, 3'b000, 0, 2'd0));
    vec.push_back(mk(3'b100, 1, 1, 2'd2, 3'b100, 0, 2'd0));
    vec.push_back(mk(3'b000, 1, 1, 2'd2, 3'b100, 1, 2'd2));
    vec.push_back(mk(3'b000, 1, 0, 2'd2, 3'b000, 0, 2'd0));
    // Input 0 drops after two accepts, input 1 then gets a full burst of four.
    vec.push_back(mk(3'b011, 1, 0, 2'd2, 3'b000, 0, 2'd0));
    vec.push_back(mk(3'b011, 1, 1, 2'd0, 3'b001, 0, 2'd0));
    vec.push_back(mk(3'b011, 1, 1, 2'd0, 3'b001, 1, 2'd0));
    vec.push_back(mk(3'b010, 1, 1, 2'd0, 3'b001, 1, 2'd0));
    vec.push_back(mk(3'b010, 1, 0, 2'd0, 3'b000, 0, 2'd0));
    vec.push_back(mk(3'b010, 1, 1, 2'd1, 3'b010, 0, 2'd0));
    vec.push_back(mk(3'b010, 1, 1, 2'd1, 3'b010, 1, 2'd1));
    vec.push_back(mk(3'b010, 1, 1, 2'd1, 3'b010, 1, 2'd1));
    vec.push_back(mk(3'b010, 1, 1, 2'd1, 3'b010, 1, 2'd1));
    vec.push_back(mk(3'b010, 1, 0, 2'd1, 3'b000, 1, 2'd1));
    vec.push_back(mk(3'b000, 1, 1, 2'd1, 3'b010, 0, 2'd0));
    vec.push_back(mk(3'b000, 1, 0, 2'd1, 3'b000, 0, 2'd0));
    // Last grant 2, then inputs 0 and 2 valid: pointer wraps to 0.
    vec.push_back(mk(3'b100, 1, 0, 2'd1, 3'b000, 0, 2'd0));
    vec.push_back(mk(3'b100, 1, 1, 2'd2, 3'b100, 0, 2'd0));
    vec.push_back(mk(3'b000, 1, 1, 2'd2, 3'b100, 1, 2'd2));
    vec.push_back(mk(3'b101, 1, 0, 2'd2, 3'b000, 0, 2'd0));
    vec.push_back(mk(3'b101, 1, 1, 2'd0, 3'b001, 0, 2'd0));
    vec.push_back(mk(3'b000, 1, 1, 2'd0, 3'b001, 1, 2'd0));
    vec.push_back(mk(3'b000, 1, 0, 2'd0, 3'b000, 0, 2'd0));

    reset       = 1'b0;
    istream_val = '0;
    ostream_rdy = 1'b0;
    for (int i = 0; i < 3; i++) lanes[i] = 32'hC0DE_0000 + 32'(i);

    #1;
    check("rst_grant_val", 64'(grant_val), 64'd0);
    check("rst_grant_idx", 64'(grant_idx), 64'd0);
    check("rst_istream_rdy", 64'(istream_rdy), 64'd0);
    check("rst_ostream_val", 64'(ostream_val), 64'd0);
    check("rst_ostream_msg", 64'(ostream_msg), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // All three requesters valid: 4 messages each in rotation, one bubble per grant change.
    for (int k = 0; k < 13; k++) begin
      ei = 2'((k / 4) % 3);
      sb_q.push_back({ei, lanes[ei]});
    end
    istream_val = 3'b111;
    ostream_rdy = 1'b1;
    nout = 0;
    last = 0;
    for (int c = 0; c < 60 && sb_q.size() > 0; c++) begin
      #1;
      if (ostream_val) begin
        if (nout > 0) check("burst_gap", 64'(cyc - last), (nout % 4 == 0) ? 64'd2 : 64'd1);
        last = cyc;
        nout++;
        sb_sample();
      end
      @(negedge clk);
    end
    check("burst_all_out", 64'(sb_q.size()), 64'd0);
    sb_q.delete();

    reset_pulse();
    lanes[0] = 32'h0000_1000;
    lanes[1] = 32'h0000_2001;
    lanes[2] = 32'h0000_00A5;
    for (int r = 0; r < vec.size(); r++) begin
      istream_val = vec[r].val;
      ostream_rdy = vec[r].ordy;
      #1;
      check($sformatf("vec%0d_grant_val", r), 64'(grant_val), 64'(vec[r].gval));
      check($sformatf("vec%0d_grant_idx", r), 64'(grant_idx), 64'(vec[r].gidx));
      check($sformatf("vec%0d_istream_rdy", r), 64'(istream_rdy), 64'(vec[r].rdy));
      check($sformatf("vec%0d_ostream_val", r), 64'(ostream_val), 64'(vec[r].oval));
      if (vec[r].oval)
        check($sformatf("vec%0d_ostream_msg", r), 64'(ostream_msg),
              64'({vec[r].oidx, lanes[vec[r].oidx]}));
      @(negedge clk);
    end

    // Backpressure: buffer full with ostream_rdy low for five cycles.
    reset_pulse();
    lanes[0]    = 32'h0000_0011;
    istream_val = 3'b001;
    ostream_rdy = 1'b0;
    sb_q.push_back({2'd0, 32'h0000_0011});
    @(negedge clk);
    #1;
    check("bp_grant_rdy", 64'(istream_rdy), 64'b001);
    @(negedge clk);
    lanes[0] = 32'h0000_0022;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_stall_rdy", 64'(istream_rdy), 64'd0);
      check("bp_stall_val", 64'(ostream_val), 64'd1);
      check("bp_stall_msg", 64'(ostream_msg), 64'({2'd0, 32'h0000_0011}));
      @(negedge clk);
    end
    ostream_rdy = 1'b1;
    #1;
    check("bp_release_rdy", 64'(istream_rdy), 64'b001);
    sb_sample();
    @(negedge clk);
    ostream_rdy = 1'b0;
    #1;
    check("bp_refill_val", 64'(ostream_val), 64'd1);
    check("bp_refill_msg", 64'(ostream_msg), 64'({2'd0, 32'h0000_0022}));
    check("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // Reset between clock edges while a message is buffered and a grant is held.
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_grant_val", 64'(grant_val), 64'd0);
    check("mid_rst_grant_idx", 64'(grant_idx), 64'd0);
    check("mid_rst_istream_rdy", 64'(istream_rdy), 64'd0);
    check("mid_rst_ostream_val", 64'(ostream_val), 64'd0);
    check("mid_rst_ostream_msg", 64'(ostream_msg), 64'd0);
    sb_q.delete();
    istream_val = '0;
    repeat (2) @(negedge clk);
    reset       = 1'b1;
    istream_val = 3'b110;
    ostream_rdy = 1'b1;
    #1;
    check("post_rst_idle", 64'(grant_val), 64'd0);
    @(negedge clk);
    #1;
    check("post_rst_grant_val", 64'(grant_val), 64'd1);
    check("post_rst_grant_idx", 64'(grant_idx), 64'd1);
    check("post_rst_rdy", 64'(istream_rdy), 64'b010);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
